// File: rtl/hamming_uart_rx.sv
// Hamming(7,4) UART receiver: 8N1 deserialiser with 3-sample majority voting,
// syndrome decode and a one-entry valid/ready output register.
// Define HAMMING_RX_CORRECT_EN to apply single-bit correction to the nibble.
module hamming_uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [3:0] data_out,
  output logic [2:0] syndrome_out,
  output logic       corrected_out,
  output logic       valid_out,
  input  logic       ready_in,
  output logic       frame_err_out,
  output logic       overrun_out,
  output logic [1:0] state_out
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_SAMP_A = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] CNT_SAMP_B = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(HALF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  function automatic logic [2:0] calc_syndrome(input logic [6:0] c);
    calc_syndrome = {c[3] ^ c[4] ^ c[5] ^ c[6],
                     c[1] ^ c[2] ^ c[5] ^ c[6],
                     c[0] ^ c[2] ^ c[4] ^ c[6]};
  endfunction

  function automatic logic [6:0] correct_word(input logic [6:0] c, input logic [2:0] s);
    logic [6:0] w;
    for (int i = 0; i < 7; i++) begin
      w[i] = c[i] ^ (s == 3'(i + 1));
    end
    correct_word = w;
  endfunction

  logic             sync1_r, sync2_r;
  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic [7:0]       shift_r, shift_s;
  logic             wait_hi_r, wait_hi_s;
  logic             samp_a_r, samp_b_r;
  logic             maj_s, decide_s;
  logic             frame_done_s, frame_err_s;
  logic [2:0]       syn_s;
  logic [6:0]       fixed_s;
  logic             corr_s;
  logic             load_s, handshake_s;

  // Two-flop synchroniser, both stages reset to the idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
    end
  end

  // Capture the two early mid-bit samples; the third is the live synced value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_a_r <= 1'b1;
      samp_b_r <= 1'b1;
    end else begin
      if (cnt_r == CNT_SAMP_A) samp_a_r <= sync2_r;
      if (cnt_r == CNT_SAMP_B) samp_b_r <= sync2_r;
    end
  end

  assign maj_s    = (samp_a_r & samp_b_r) | (samp_a_r & sync2_r) | (samp_b_r & sync2_r);
  assign decide_s = (cnt_r == CNT_DECIDE);

  // Receive FSM next-state, bit counter and shift register
  always_comb begin
    state_s      = state_r;
    bit_idx_s    = bit_idx_r;
    shift_s      = shift_r;
    wait_hi_s    = wait_hi_r;
    frame_done_s = 1'b0;
    frame_err_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!sync2_r) state_s = START;
        else          state_s = IDLE;
      end
      START: begin
        if (decide_s && maj_s) begin
          state_s = IDLE;
        end else if (decide_s) begin
          state_s   = DATA;
          bit_idx_s = 3'd0;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (decide_s) begin
          shift_s = {maj_s, shift_r[7:1]};
          if (bit_idx_r == 3'd7) state_s = STOP;
          else                   bit_idx_s = bit_idx_r + 3'd1;
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        // After a framing error, hold here until the line returns high
        if (wait_hi_r) begin
          if (sync2_r) begin
            state_s   = IDLE;
            wait_hi_s = 1'b0;
          end else begin
            state_s = STOP;
          end
        end else if (decide_s) begin
          if (maj_s) begin
            frame_done_s = 1'b1;
            state_s      = IDLE;
          end else begin
            frame_err_s = 1'b1;
            wait_hi_s   = 1'b1;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s   = IDLE;
        wait_hi_s = 1'b0;
      end
    endcase
    if (state_s == IDLE)        cnt_s = CNT_ZERO;
    else if (cnt_r == CNT_LAST) cnt_s = CNT_ZERO;
    else                        cnt_s = cnt_r + CNT_ONE;
  end

  // FSM and bit-timing state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      wait_hi_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      wait_hi_r <= wait_hi_s;
    end
  end

  assign syn_s = calc_syndrome(shift_r[6:0]);
`ifdef HAMMING_RX_CORRECT_EN
  assign fixed_s = correct_word(shift_r[6:0], syn_s);
  assign corr_s  = (syn_s != 3'd0);
`else
  assign fixed_s = shift_r[6:0];
  assign corr_s  = 1'b0;
`endif

  assign handshake_s = valid_out & ready_in;
  assign load_s      = frame_done_s & (~valid_out | ready_in);

  // One-entry output register with overrun and framing-error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out      <= 4'd0;
      syndrome_out  <= 3'd0;
      corrected_out <= 1'b0;
      valid_out     <= 1'b0;
      overrun_out   <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      frame_err_out <= frame_err_s;
      if (load_s) begin
        data_out      <= {fixed_s[6], fixed_s[5], fixed_s[4], fixed_s[2]};
        syndrome_out  <= syn_s;
        corrected_out <= corr_s;
        valid_out     <= 1'b1;
      end else if (frame_done_s) begin
        overrun_out <= 1'b1;
      end else if (handshake_s) begin
        valid_out   <= 1'b0;
        overrun_out <= 1'b0;
      end
    end
  end

  assign state_out = state_r;

endmodule

// File: tb/tb_hamming_uart_rx.sv
// Self-checking bench for hamming_uart_rx: frame-timeline model plus pinned
// literal expectations; honours HAMMING_RX_CORRECT_EN like the design.
module tb_hamming_uart_rx;

  localparam int CPB      = 16;
  localparam int H        = CPB / 2;
  localparam int START_END = H + 1;
  localparam int DATA_END  = 8 * CPB + H + 1;
  localparam int DONE_OFS  = 9 * CPB + H + 1;
  localparam int K_OK = 0, K_ERR = 1, K_GLITCH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       ready_in = 1'b0;
  logic [3:0] data_out;
  logic [2:0] syndrome_out;
  logic       corrected_out, valid_out, frame_err_out, overrun_out;
  logic [1:0] state_out;

  hamming_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx),
    .data_out(data_out), .syndrome_out(syndrome_out), .corrected_out(corrected_out),
    .valid_out(valid_out), .ready_in(ready_in), .frame_err_out(frame_err_out),
    .overrun_out(overrun_out), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    int         kind;
    logic [7:0] b;
    int         hold;
  } frame_t;

  frame_t     fq[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic       exp_valid = 1'b0, exp_ferr = 1'b0, exp_ovr = 1'b0;
  logic [7:0] exp_dec = 8'd0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Syndrome = XOR of the 1-based positions of all set bits; result {corr, syn, nibble}
  function automatic logic [7:0] model_decode(input logic [7:0] b);
    int         s;
    logic [6:0] c;
    logic       corr;
    s = 0;
    c = b[6:0];
    for (int i = 0; i < 7; i++) if (c[i]) s = s ^ (i + 1);
`ifdef HAMMING_RX_CORRECT_EN
    if (s != 0) c[s-1] = ~c[s-1];
    corr = (s != 0);
`else
    corr = 1'b0;
`endif
    return {corr, s[2:0], c[6], c[5], c[4], c[2]};
  endfunction

  function automatic int exp_state(input int c);
    int st;
    int stop_end;
    st = 0;
    foreach (fq[i]) begin
      stop_end = (fq[i].kind == K_ERR) ? fq[i].t + 9 * CPB + fq[i].hold : fq[i].t + DONE_OFS;
      if (c >= fq[i].t + 1 && c <= fq[i].t + START_END) st = 1;
      if (fq[i].kind != K_GLITCH) begin
        if (c > fq[i].t + START_END && c <= fq[i].t + DATA_END) st = 2;
        if (c > fq[i].t + DATA_END && c <= stop_end) st = 3;
      end
    end
    return st;
  endfunction

  function automatic logic [7:0] pick(input int sel);
    case (sel)
      0: return {7'd0, valid_out};
      1: return {4'd0, data_out};
      2: return {5'd0, syndrome_out};
      3: return {7'd0, corrected_out};
      4: return {7'd0, frame_err_out};
      5: return {7'd0, overrun_out};
      default: return {6'd0, state_out};
    endcase
  endfunction

  // Model of the output register, advanced once per clock
  always @(posedge clk) begin
    int         c;
    logic       done_ok, ferr;
    logic [7:0] db;
    c = cyc;
    done_ok = 1'b0;
    ferr = 1'b0;
    db = 8'd0;
    if (!rst_n) begin
      exp_valid = 1'b0;
      exp_ferr  = 1'b0;
      exp_ovr   = 1'b0;
      exp_dec   = 8'd0;
      fq.delete();
    end else begin
      foreach (fq[i]) begin
        if (c == fq[i].t + DONE_OFS && fq[i].kind == K_OK) begin
          done_ok = 1'b1;
          db = fq[i].b;
        end
        if (c == fq[i].t + DONE_OFS && fq[i].kind == K_ERR) ferr = 1'b1;
      end
      exp_ferr = ferr;
      if (done_ok && (!exp_valid || ready_in)) begin
        exp_dec   = model_decode(db);
        exp_valid = 1'b1;
      end else if (done_ok) begin
        exp_ovr = 1'b1;
      end else if (exp_valid && ready_in) begin
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
      end
    end
    cyc = cyc + 1;
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_data", {4'd0, data_out}, 8'd0);
      chk("rst_syn", {5'd0, syndrome_out}, 8'd0);
      chk("rst_corr", {7'd0, corrected_out}, 8'd0);
      chk("rst_valid", {7'd0, valid_out}, 8'd0);
      chk("rst_ferr", {7'd0, frame_err_out}, 8'd0);
      chk("rst_ovr", {7'd0, overrun_out}, 8'd0);
      chk("rst_state", {6'd0, state_out}, 8'd0);
    end else begin
      chk("valid", {7'd0, valid_out}, {7'd0, exp_valid});
      chk("frame_err", {7'd0, frame_err_out}, {7'd0, exp_ferr});
      chk("overrun", {7'd0, overrun_out}, {7'd0, exp_ovr});
      chk("state", {6'd0, state_out}, 8'(exp_state(cyc)));
      if (exp_valid) begin
        chk("data", {4'd0, data_out}, {4'd0, exp_dec[3:0]});
        chk("syndrome", {5'd0, syndrome_out}, {5'd0, exp_dec[6:4]});
        chk("corrected", {7'd0, corrected_out}, {7'd0, exp_dec[7]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int at, input int sel, input logic [7:0] val, input string name);
    do @(negedge clk); while (cyc < at);
    chk(name, pick(sel), val);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len, input int kind);
    frame_t r;
    r.t = cyc + 2;
    r.kind = kind;
    r.b = b;
    r.hold = stop_len;
    fq.push_back(r);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop_v;
    repeat (stop_len) tick();
    rx = 1'b1;
  endtask

  initial begin
    int     t;
    frame_t r;
    logic [7:0] b;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    ready_in = 1'b1;
    repeat (5) tick();

    // Clean 0x55 -> nibble 0xB, valid for exactly one cycle at T+154
    t = cyc + 2;
    fork
      expect_at(t + 153, 0, 8'd0, "clean_valid_before");
      expect_at(t + 154, 0, 8'd1, "clean_valid_rise");
      expect_at(t + 154, 1, 8'hB, "clean_data");
      expect_at(t + 154, 2, 8'd0, "clean_syn");
      expect_at(t + 155, 0, 8'd0, "clean_valid_fall");
    join_none
    send_frame(8'h55, 1'b1, CPB, K_OK);
    repeat (8) tick();

    // 0x45: c4 flipped, syndrome 5
    t = cyc + 2;
    fork
      expect_at(t + 154, 2, 8'd5, "c4_syn");
`ifdef HAMMING_RX_CORRECT_EN
      expect_at(t + 154, 1, 8'hB, "c4_data");
      expect_at(t + 154, 3, 8'd1, "c4_corr");
`else
      expect_at(t + 154, 1, 8'h9, "c4_data");
      expect_at(t + 154, 3, 8'd0, "c4_corr");
`endif
    join_none
    send_frame(8'h45, 1'b1, CPB, K_OK);
    repeat (8) tick();

    // Stop bit 0, line held low 40 cycles
    t = cyc + 2;
    fork
      expect_at(t + 153, 4, 8'd0, "ferr_before");
      expect_at(t + 154, 4, 8'd1, "ferr_pulse");
      expect_at(t + 155, 4, 8'd0, "ferr_after");
      expect_at(t + 154, 0, 8'd0, "ferr_no_valid");
      expect_at(t + 184, 6, 8'd3, "ferr_stop_hold");
      expect_at(t + 185, 6, 8'd0, "ferr_idle");
    join_none
    send_frame(8'h55, 1'b0, 40, K_ERR);
    repeat (10) tick();

    // Back-to-back 0x55, 0x00 with consumer stalled -> overrun
    ready_in = 1'b0;
    t = cyc + 2;
    fork
      expect_at(t + 154, 0, 8'd1, "ovr_first_valid");
      expect_at(t + 9 * CPB + CPB + 153, 5, 8'd0, "ovr_before");
      expect_at(t + 9 * CPB + CPB + 154, 5, 8'd1, "ovr_set");
      expect_at(t + 9 * CPB + CPB + 154, 1, 8'hB, "ovr_data_held");
    join_none
    send_frame(8'h55, 1'b1, CPB, K_OK);
    send_frame(8'h00, 1'b1, CPB, K_OK);
    repeat (10) tick();
    ready_in = 1'b1;
    t = cyc + 1;
    fork
      expect_at(t, 0, 8'd0, "ovr_valid_clear");
      expect_at(t, 5, 8'd0, "ovr_clear");
    join_none
    repeat (6) tick();

    // 3-cycle glitch: false start
    t = cyc + 2;
    r.t = t; r.kind = K_GLITCH; r.b = 8'd0; r.hold = 0;
    fq.push_back(r);
    fork
      expect_at(t + 5, 6, 8'd1, "glitch_start");
      expect_at(t + 10, 6, 8'd0, "glitch_idle");
    join_none
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (40) tick();

    // Reset during data bit 4, then a clean frame
    b = 8'h55;
    r.t = cyc + 2; r.kind = K_OK; r.b = b; r.hold = CPB;
    fq.push_back(r);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = b[4];
    repeat (5) tick();
    chk("pre_reset_state", {6'd0, state_out}, 8'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_state", {6'd0, state_out}, 8'd0);
    repeat (2) tick();
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (5) tick();
    t = cyc + 2;
    fork
      expect_at(t + 154, 0, 8'd1, "post_rst_valid");
      expect_at(t + 154, 1, 8'hB, "post_rst_data");
    join_none
    send_frame(8'h55, 1'b1, CPB, K_OK);
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
